mprj_checkpoint_monitor: RTL and testbench
==========================================

// Module: mprj_checkpoint_monitor
// PURPOSE
//  Synthesizable checkpoint checker for the management SoC self-test. Firmware publishes {code,value} on user IO.
//  The block watches that word and filters glitches. It matches each code against a programmable table of
//  expected values (with masks) and reports pass/fail/timeout. N-entry, width-parametrised successor to
//  fixed-sequence bench monitors; usable in silicon bring-up and in DV.
// PARAMETERS
//  CODE_W     6      checkpoint code width (upper IO bits)
//  VAL_W      32     checkpoint value width (lower IO bits)
//  N_CHK      8      expected-table depth (>=1); AW = $clog2(N_CHK), min 1
//  SETTLE     2      cycles {code,val} must be unchanged before it is accepted (>=1)
//  TMO_W      24     timeout counter width
//  START_CODE 6'h04  code that arms checking
//  END_CODE   6'h0d  code that ends the sequence
// PORTS
//  wb_clk_i    in   1       clock
//  wb_rst_i    in   1       synchronous reset, active high
//  code_in     in   CODE_W  checkpoint code from IO
//  val_in      in   VAL_W   checkpoint value from IO
//  start       in   1       1-cycle pulse: arm monitor (honoured in IDLE/DONE only)
//  tbl_we      in   1       table write strobe (ignored while busy)
//  tbl_addr    in   AW      table entry index
//  tbl_code    in   CODE_W  expected code for entry
//  tbl_val     in   VAL_W   expected value for entry
//  tbl_mask    in   VAL_W   compare mask for entry (1 = bit compared)
//  n_used      in   AW+1    entries in use (0..N_CHK; >N_CHK treated as N_CHK); sampled at start
//  tmo_limit   in   TMO_W   cycles allowed between accepted checkpoints; 0 = disabled; sampled at start
//  busy        out  1       monitor armed (WAIT_START/RUN/WAIT_END)
//  done        out  1       terminal result valid
//  result      out  2       00 none, 01 pass, 10 fail, 11 timeout
//  fail_idx    out  AW+1    entry index at fail/timeout (n_used if END seen early or failing in WAIT_END)
//  fail_val    out  VAL_W   accepted value that failed (0 on timeout)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, result, fail_idx, fail_val, idx, timers, table contents all 0.
//  Settle filter: word w={code_in,val_in} is registered each cycle. A stable count increments while
//   w==w_prev and clears on change. The word is "accepted" once, on the cycle the count reaches SETTLE.
//   Accepted code/value are registered; a change in w re-arms acceptance. Acceptance is decided 1 cycle after
//   the SETTLE-th stable sample. Shorter pulses are ignored.
//  States: IDLE, WAIT_START, RUN, WAIT_END, DONE.
//   IDLE/DONE + start: clear result/fail_*, idx=0, timer=0, latch n_used/tmo_limit -> WAIT_START.
//   WAIT_START: accepted code==START_CODE -> RUN (n_used==0 -> WAIT_END). Other codes are ignored.
//   RUN: accepted code==tbl_code[idx]. Compare (val & mask)==(tbl_val & mask).
//     match: idx+1. If idx==n_used-1 -> WAIT_END, else stay in RUN.
//     mismatch: result=10, fail_idx=idx, fail_val=val -> DONE.
//    accepted END_CODE in RUN: result=10, fail_idx=n_used, fail_val=val -> DONE.
//    any other code is ignored (no timer reset).
//   WAIT_END: accepted END_CODE -> result=01 -> DONE. Other codes are ignored.
//  Timer: increments each cycle while busy. Clears on entry to WAIT_START and on each state-advancing acceptance.
//   If tmo_limit!=0 and timer==tmo_limit-1: result=11, fail_idx=idx (n_used in WAIT_END), fail_val=0 -> DONE.
//   If a timeout and an acceptance land in the same cycle, the acceptance wins.
//  done=1 and result hold in DONE until start or reset. busy=0 in IDLE/DONE.
//  Table writes land the cycle after tbl_we. Out-of-range tbl_addr is ignored. Writes while busy are dropped.
//  A start pulse while busy is ignored. Reset mid-sequence returns to IDLE with all outputs 0.
// TESTING
//  1 Load 8 entries, codes 05..0C: 00045611,0,2,1,03ffefff,12,4,1809; masks ffffffff; n_used=8.
//    Drive 04, then 05..0C with those values, then 0d. Each held 10 cycles -> done=1, result=01.
//  2 As 1, but entry 4 value is 03ffeffe -> result=10, fail_idx=4, fail_val=03ffeffe; done in DONE.
//  3 SETTLE=2: 1-cycle glitch to code 05 with bad value, then the correct word is held -> glitch ignored, pass.
//  4 tmo_limit=100, start, no codes -> result=11 exactly 100 cycles after start accepted, fail_idx=0.
//  5 After 3 matches, drive 0d -> result=10, fail_idx=8. Entry mask 0000ffff with high bits differing -> match.
//  6 Reset asserted in RUN at idx=5 -> next cycle IDLE, busy=done=result=0. Table writes while busy are dropped.

Source files
------------

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint monitor: settles the {code,value} word from user IO and checks the accepted
// checkpoints against a programmable, masked table, ending in pass, fail or timeout.
module mprj_checkpoint_monitor #(
    parameter int                CODE_W     = 6,
    parameter int                VAL_W      = 32,
    parameter int                N_CHK      = 8,
    parameter int                SETTLE     = 2,
    parameter int                TMO_W      = 24,
    parameter logic [CODE_W-1:0] START_CODE = 'h04,
    parameter logic [CODE_W-1:0] END_CODE   = 'h0d,
    localparam int               AW         = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [CODE_W-1:0] code_in,
    input  logic [VAL_W-1:0]  val_in,
    input  logic              start,
    input  logic              tbl_we,
    input  logic [AW-1:0]     tbl_addr,
    input  logic [CODE_W-1:0] tbl_code,
    input  logic [VAL_W-1:0]  tbl_val,
    input  logic [VAL_W-1:0]  tbl_mask,
    input  logic [AW:0]       n_used,
    input  logic [TMO_W-1:0]  tmo_limit,
    output logic              busy,
    output logic              done,
    output logic [1:0]        result,
    output logic [AW:0]       fail_idx,
    output logic [VAL_W-1:0]  fail_val,
    output logic [2:0]        dbg_state_o
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_RUN, S_WAIT_END, S_DONE} state_t;

    localparam int W  = CODE_W + VAL_W;
    localparam int CW = $clog2(SETTLE + 1);
    localparam int TD = 1 << AW;

    logic [W-1:0]      w_in, w_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              same, acc_hit, acc_q;
    logic [CODE_W-1:0] acc_code_q;
    logic [VAL_W-1:0]  acc_val_q;

    logic [CODE_W-1:0] t_code_q [TD];
    logic [VAL_W-1:0]  t_val_q  [TD];
    logic [VAL_W-1:0]  t_mask_q [TD];

    state_t            state_q, state_d;
    logic [AW:0]       idx_q, idx_d, nused_q, nused_d, fidx_q, fidx_d, n_clamp;
    logic [TMO_W-1:0]  timer_q, timer_d, tmo_q, tmo_d;
    logic [1:0]        result_q, result_d;
    logic [VAL_W-1:0]  fval_q, fval_d;
    logic [CODE_W-1:0] cur_code;
    logic [VAL_W-1:0]  cur_val, cur_mask;
    logic              val_match, last, adv;

    // A word is accepted exactly once, when it has compared equal to the previous sample SETTLE times.
    assign w_in    = {code_in, val_in};
    assign same    = (w_in == w_q);
    assign acc_hit = same && (cnt_q == CW'(SETTLE - 1));

    always_comb begin
        cnt_d = '0;
        if (same) cnt_d = (cnt_q == CW'(SETTLE)) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            w_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            acc_code_q <= '0;
            acc_val_q  <= '0;
        end else begin
            w_q   <= w_in;
            cnt_q <= cnt_d;
            acc_q <= acc_hit;
            if (acc_hit) begin
                acc_code_q <= w_q[W-1:VAL_W];
                acc_val_q  <= w_q[VAL_W-1:0];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < TD; i++) begin
                t_code_q[i] <= '0;
                t_val_q[i]  <= '0;
                t_mask_q[i] <= '0;
            end
        end else if (tbl_we && !busy && ({1'b0, tbl_addr} < (AW+1)'(N_CHK))) begin
            t_code_q[tbl_addr] <= tbl_code;
            t_val_q[tbl_addr]  <= tbl_val;
            t_mask_q[tbl_addr] <= tbl_mask;
        end
    end

    assign busy        = (state_q == S_WAIT_START) || (state_q == S_RUN) || (state_q == S_WAIT_END);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign fail_idx    = fidx_q;
    assign fail_val    = fval_q;
    assign dbg_state_o = state_q;

    assign n_clamp   = (n_used > (AW+1)'(N_CHK)) ? (AW+1)'(N_CHK) : n_used;
    assign cur_code  = t_code_q[idx_q[AW-1:0]];
    assign cur_val   = t_val_q[idx_q[AW-1:0]];
    assign cur_mask  = t_mask_q[idx_q[AW-1:0]];
    assign val_match = ((acc_val_q ^ cur_val) & cur_mask) == '0;
    assign last      = (idx_q == nused_q - (AW+1)'(1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        nused_d  = nused_q;
        tmo_d    = tmo_q;
        result_d = result_q;
        fidx_d   = fidx_q;
        fval_d   = fval_q;
        adv      = 1'b0;
        if (busy) timer_d = timer_q + TMO_W'(1);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_WAIT_START;
                    idx_d    = '0;
                    timer_d  = '0;
                    nused_d  = n_clamp;
                    tmo_d    = tmo_limit;
                    result_d = 2'b00;
                    fidx_d   = '0;
                    fval_d   = '0;
                end
            end
            S_WAIT_START: begin
                if (acc_q && acc_code_q == START_CODE) begin
                    adv     = 1'b1;
                    timer_d = '0;
                    state_d = (nused_q == '0) ? S_WAIT_END : S_RUN;
                end
            end
            S_RUN: begin
                if (acc_q && acc_code_q == cur_code) begin
                    adv     = 1'b1;
                    timer_d = '0;
                    if (val_match) begin
                        idx_d = idx_q + (AW+1)'(1);
                        if (last) state_d = S_WAIT_END;
                    end else begin
                        state_d  = S_DONE;
                        result_d = 2'b10;
                        fidx_d   = idx_q;
                        fval_d   = acc_val_q;
                    end
                end else if (acc_q && acc_code_q == END_CODE) begin
                    adv      = 1'b1;
                    state_d  = S_DONE;
                    result_d = 2'b10;
                    fidx_d   = nused_q;
                    fval_d   = acc_val_q;
                end
            end
            S_WAIT_END: begin
                if (acc_q && acc_code_q == END_CODE) begin
                    adv      = 1'b1;
                    state_d  = S_DONE;
                    result_d = 2'b01;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // An acceptance in the same cycle as expiry takes priority over the timeout.
        if (busy && !adv && tmo_q != '0 && timer_q == tmo_q - TMO_W'(1)) begin
            state_d  = S_DONE;
            result_d = 2'b11;
            fidx_d   = (state_q == S_WAIT_END) ? nused_q : idx_q;
            fval_d   = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            timer_q  <= '0;
            nused_q  <= '0;
            tmo_q    <= '0;
            result_q <= 2'b00;
            fidx_q   <= '0;
            fval_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            nused_q  <= nused_d;
            tmo_q    <= tmo_d;
            result_q <= result_d;
            fidx_q   <= fidx_d;
            fval_q   <= fval_d;
        end
    end
endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Directed bench for mprj_checkpoint_monitor: full pass, value fail, glitch rejection,
// timeout timing, early END, masked compare, busy-time write drop, start-while-busy and reset.
module tb_mprj_checkpoint_monitor;
    localparam int AW = 3;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic [5:0]    code_in;
    logic [31:0]   val_in;
    logic          start;
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic [5:0]    tbl_code;
    logic [31:0]   tbl_val;
    logic [31:0]   tbl_mask;
    logic [AW:0]   n_used;
    logic [23:0]   tmo_limit;
    logic          busy;
    logic          done;
    logic [1:0]    result;
    logic [AW:0]   fail_idx;
    logic [31:0]   fail_val;
    logic [2:0]    dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] vals [8] = '{32'h00045611, 32'h0, 32'h2, 32'h1,
                              32'h03ffefff, 32'h12, 32'h4, 32'h1809};

    localparam logic [2:0] ST_IDLE = 3'd0, ST_WSTART = 3'd1, ST_RUN = 3'd2,
                           ST_WEND = 3'd3, ST_DONE = 3'd4;

    mprj_checkpoint_monitor dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .code_in    (code_in),
        .val_in     (val_in),
        .start      (start),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_code   (tbl_code),
        .tbl_val    (tbl_val),
        .tbl_mask   (tbl_mask),
        .n_used     (n_used),
        .tmo_limit  (tmo_limit),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .fail_idx   (fail_idx),
        .fail_val   (fail_val),
        .dbg_state_o(dbg_state_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [5:0] c,
                               input logic [31:0] v, input logic [31:0] m);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_code = c;
        tbl_val  = v;
        tbl_mask = m;
        @(negedge wb_clk_i);
        tbl_we   = 1'b0;
    endtask

    task automatic drive_word(input logic [5:0] c, input logic [31:0] v, input int n);
        code_in = c;
        val_in  = v;
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge wb_clk_i);
        end
        check(tag, done, 1'b1);
    endtask

    initial begin
        wb_rst_i = 1'b1; code_in = '0; val_in = '0; start = 1'b0; tbl_we = 1'b0;
        tbl_addr = '0; tbl_code = '0; tbl_val = '0; tbl_mask = '0;
        n_used = 4'd8; tmo_limit = '0;
        repeat (3) @(negedge wb_clk_i);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 2'b00);
        check("rst_fail_idx", fail_idx, 4'd0);
        check("rst_fail_val", fail_val, 32'h0);
        check("rst_state", dbg_state_o, ST_IDLE);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // 1: full passing sequence
        for (int i = 0; i < 8; i++) write_entry(AW'(i), 6'(5 + i), vals[i], 32'hffffffff);
        pulse_start();
        check("t1_busy", busy, 1'b1);
        check("t1_wait_start", dbg_state_o, ST_WSTART);
        drive_word(6'h04, 32'h0, 10);
        check("t1_run", dbg_state_o, ST_RUN);
        for (int i = 0; i < 8; i++) drive_word(6'(5 + i), vals[i], 10);
        check("t1_wait_end", dbg_state_o, ST_WEND);
        drive_word(6'h0d, 32'h0, 10);
        wait_done("t1_done", 20);
        check("t1_result", result, 2'b01);
        check("t1_busy_off", busy, 1'b0);

        // 2: value mismatch at entry 4
        pulse_start();
        check("t2_cleared_result", result, 2'b00);
        check("t2_cleared_done", done, 1'b0);
        drive_word(6'h04, 32'h0, 10);
        for (int i = 0; i < 4; i++) drive_word(6'(5 + i), vals[i], 10);
        drive_word(6'h09, 32'h03ffeffe, 10);
        wait_done("t2_done", 20);
        check("t2_result", result, 2'b10);
        check("t2_fail_idx", fail_idx, 4'd4);
        check("t2_fail_val", fail_val, 32'h03ffeffe);
        check("t2_state", dbg_state_o, ST_DONE);
        drive_word(6'h0a, 32'h12, 5);
        check("t2_hold_result", result, 2'b10);

        // 3: one-cycle glitch with a bad value must be ignored
        pulse_start();
        drive_word(6'h04, 32'h0, 10);
        drive_word(6'h05, 32'hffffffff, 1);
        drive_word(6'h05, vals[0], 10);
        check("t3_after_glitch", dbg_state_o, ST_RUN);
        for (int i = 1; i < 8; i++) drive_word(6'(5 + i), vals[i], 10);
        drive_word(6'h0d, 32'h0, 10);
        wait_done("t3_done", 20);
        check("t3_result", result, 2'b01);

        // 4: timeout exactly 100 cycles after start with no checkpoints
        drive_word(6'h00, 32'h0, 5);
        tmo_limit = 24'd100;
        pulse_start();
        tmo_limit = 24'd0;
        repeat (99) @(negedge wb_clk_i);
        check("t4_not_yet_done", done, 1'b0);
        check("t4_still_busy", busy, 1'b1);
        @(negedge wb_clk_i);
        check("t4_done", done, 1'b1);
        check("t4_result", result, 2'b11);
        check("t4_fail_idx", fail_idx, 4'd0);
        check("t4_fail_val", fail_val, 32'h0);

        // 5: masked compare on entry 3, then END early
        write_entry(3'd3, 6'h08, 32'h00000001, 32'h0000ffff);
        pulse_start();
        drive_word(6'h04, 32'h0, 10);
        for (int i = 0; i < 3; i++) drive_word(6'(5 + i), vals[i], 10);
        drive_word(6'h08, 32'hab0c0001, 10);
        check("t5_masked_match", dbg_state_o, ST_RUN);
        drive_word(6'h0d, 32'h55, 10);
        wait_done("t5_done", 20);
        check("t5_result", result, 2'b10);
        check("t5_fail_idx", fail_idx, 4'd8);
        check("t5_fail_val", fail_val, 32'h55);

        // 6: start while busy ignored, write while busy dropped, reset mid-run
        pulse_start();
        drive_word(6'h04, 32'h0, 10);
        pulse_start();
        check("t6_start_ignored", dbg_state_o, ST_RUN);
        drive_word(6'h05, vals[0], 10);
        drive_word(6'h06, vals[1], 10);
        drive_word(6'h07, vals[2], 10);
        drive_word(6'h08, 32'h00000001, 10);
        write_entry(3'd4, 6'h09, 32'hdeadbeef, 32'hffffffff);
        drive_word(6'h09, vals[4], 10);
        check("t6_write_dropped", dbg_state_o, ST_RUN);
        check("t6_no_done", done, 1'b0);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("t6_rst_state", dbg_state_o, ST_IDLE);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_result", result, 2'b00);
        check("t6_rst_fail_idx", fail_idx, 4'd0);
        check("t6_rst_fail_val", fail_val, 32'h0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
